// File: rtl/ahb_subordinate_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_subordinate_mem
//  Purpose  : AHB-Lite subordinate backed by a small word-organised register
//             memory. Supports byte/halfword/word accesses, inserts a fixed
//             number of wait states per OKAY transfer and answers illegal
//             accesses with a two-cycle ERROR response.
//  Ports    : HCLK, HRESETn           - clock, async active-low reset
//             HSEL, HADDR, HTRANS,
//             HWRITE, HSIZE, HREADY   - address-phase inputs from manager
//             HWDATA                  - write data (data phase)
//             HREADYOUT, HRESP,
//             HRDATA                  - data-phase response to manager
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_subordinate_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          MEM_WORDS   = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        lane_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [31:0]       mem [MEM_WORDS];

  logic              accept;
  logic              take;
  logic              misaligned;
  logic              out_of_range;
  logic              err_flag;
  logic [IDX_W+1:0]  offset_lo;
  logic [3:0]        byte_en;
  state_t            start_state;

  // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike.
  logic unused_bits;
  assign unused_bits = HTRANS[0];

  assign accept = HSEL && HREADY && HTRANS[1];

  // Only the low bits of the offset are needed for the word index; the upper
  // bits are covered by the range check. BASE_ADDR is word aligned, so the
  // two low offset bits equal the byte lane.
  assign offset_lo    = HADDR[IDX_W+1:0] - BASE_ADDR[IDX_W+1:0];
  assign misaligned   = ((HSIZE == 3'b001) && HADDR[0]) ||
                        ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign out_of_range = (HADDR < BASE_ADDR) || ({1'b0, HADDR} >= END_ADDR);
  assign err_flag     = (HSIZE > 3'b010) || misaligned || out_of_range;

  assign start_state  = err_flag ? ST_ERR1 : (HAS_WAIT ? ST_WAIT : ST_DATA);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    take      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          take    = 1'b1;
          state_d = start_state;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DATA, ST_ERR2: begin
        HRESP = (state_q == ST_ERR2);
        // Final data-phase cycle: a pipelined address phase may start here.
        if (accept) begin
          take    = 1'b1;
          state_d = start_state;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      write_q <= 1'b0;
      size_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= offset_lo[IDX_W+1:2];
        lane_q  <= offset_lo[1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Byte enables for the committed write; illegal sizes never reach DATA.
  always_comb begin
    case (size_q)
      3'b000:  byte_en = 4'b0001 << lane_q;
      3'b001:  byte_en = 4'b0011 << lane_q;
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if ((state_q == ST_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : 32'h0;

endmodule
`default_nettype wire
